m_cycle_cpu: RTL and testbench

Multi-cycle MIPS-subset core; successor to the single-cycle top, with a state-machine controller sequencing fetch, decode, execute, memory and writeback.
Uses one shared, stallable instruction/data memory port with a req/ready handshake, instead of a combinational instruction memory.
Adds loads, stores, branches, jumps, halt and trap, and a parametrised reset vector and address width.

---
 rtl/m_cycle_cpu.sv | 209 ++++++++++++++++++++
 tb/tb_m_cycle_cpu.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_cycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB controller around one
// shared request/ready memory port, with terminal HALT (syscall) and TRAP states.
module m_cycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic [31:0]       pc_out,
  output logic              halted,
  output logic              trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SYSCALL = 6'h0C, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, retire_q, retire_d;
  logic              halted_q, halted_d, trap_q, trap_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       gpr_q [32];
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, imm_zext, ea;
  logic [25:0] target;
  logic        accept;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign target   = ir_q[25:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {16'h0000, ir_q[15:0]};
  assign ea       = a_q + imm_sext;
  // mem_ready is only meaningful while a request is actually outstanding
  assign accept   = mem_req_q && mem_ready;

  function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
    logic ok;
    ok = 1'b0;
    case (o)
      OP_RTYPE: ok = (f == FN_SLL) || (f == FN_SYSCALL) || (f == FN_ADDU) || (f == FN_SUBU) ||
                     (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
      OP_J, OP_BEQ, OP_ADDIU, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] rtype_alu(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    logic signed [31:0] as, bs;
    logic [31:0]        r;
    as = a;
    bs = b;
    case (f)
      FN_ADDU: r = a + b;
      FN_SUBU: r = a - b;
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      FN_SLT:  r = (as < bs) ? 32'd1 : 32'd0;
      FN_SLL:  r = b << sh;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = alu_q;
    case (state_q)
      S_FETCH: if (accept) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = gpr_q[rs];
        b_d     = gpr_q[rt];
        state_d = is_legal(op, funct) ? S_EXEC : S_TRAP;
      end
      S_EXEC: case (op)
        OP_RTYPE: if (funct == FN_SYSCALL) state_d = S_HALT;
                  else begin
                    alu_d   = rtype_alu(funct, a_q, b_q, shamt);
                    state_d = S_WB;
                  end
        OP_ADDIU: begin alu_d = ea;              state_d = S_WB; end
        OP_ORI:   begin alu_d = a_q | imm_zext; state_d = S_WB; end
        OP_LW, OP_SW: begin
          alu_d   = ea;
          state_d = (ea[1:0] != 2'b00) ? S_TRAP : S_MEM;
        end
        OP_BEQ: begin
          if (a_q == b_q) pc_d = pc_q + (imm_sext << 2);
          state_d = S_FETCH;
        end
        OP_J: begin
          pc_d    = {pc_q[31:28], target, 2'b00};
          state_d = S_FETCH;
        end
        default: state_d = S_TRAP;
      endcase
      S_MEM: if (accept) begin
        if (op == OP_LW) begin
          alu_d   = mem_rdata;
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        wr_en   = 1'b1;
        wr_addr = (op == OP_RTYPE) ? rd : rt;
        state_d = S_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  // Port and status outputs are registered, derived from the state being entered
  always_comb begin
    mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_we_d    = (state_d == S_MEM) && (op == OP_SW);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == S_FETCH) mem_addr_d = pc_d[ADDR_W-1:0];
    else if (state_d == S_MEM) mem_addr_d = alu_d[ADDR_W-1:0];
    if (mem_we_d) mem_wdata_d = b_q;
    retire_d = (state_d == S_WB) ||
               (((state_q == S_EXEC) || (state_q == S_MEM)) && (state_d == S_FETCH));
    halted_d = (state_d == S_HALT);
    trap_d   = (state_d == S_TRAP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      retire_q    <= 1'b0;
      halted_q    <= 1'b0;
      trap_q      <= 1'b0;
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_q       <= alu_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      retire_q    <= retire_d;
      halted_q    <= halted_d;
      trap_q      <= trap_d;
      // $0 is never written, so it keeps its reset value of zero
      if (wr_en && (wr_addr != 5'd0)) gpr_q[wr_addr] <= wr_data;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign retire    = retire_q;
  assign pc_out    = pc_q;
  assign halted    = halted_q;
  assign trap      = trap_q;

endmodule

// File: tb/tb_m_cycle_cpu.sv
// Scoreboard bench for m_cycle_cpu: an instruction-level reference model predicts
// the bus transactions and final state; a monitor checks each accepted request.
module tb_m_cycle_cpu;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          AW     = 16;
  localparam logic [31:0] AMASK  = 32'h0000_FFFF;
  localparam int          MW     = 1024;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  logic          clock = 1'b0, reset = 1'b1;
  logic          mem_req, mem_we, retire, halted, trap;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, pc_out;
  logic [31:0]   mem_rdata = 32'h0;

  always #5 clock = ~clock;

  m_cycle_cpu #(.RESET_PC(RST_PC), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .retire(retire), .pc_out(pc_out),
    .halted(halted), .trap(trap)
  );

  typedef struct {
    bit          we;
    bit          fetch;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } txn_t;

  int          checks = 0, errors = 0;
  txn_t        expq[$];
  logic [31:0] img [MW];
  logic [31:0] tbmem [MW];
  logic [31:0] mmem [MW];
  logic [31:0] mreg [32];
  int          ready_mode = 0;
  bit          mon_en = 0, allow_extra = 0, gap_chk = 0;
  int          cyc, last_fetch, ret_cnt;
  int          ret_cycs[$];
  logic [31:0] exp_pc;
  bit          exp_halt, exp_trap;
  int          exp_ret;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    img[addr[11:2]] = word;
  endtask

  task automatic fill_random();
    for (int i = 0; i < MW; i++) img[i] = $urandom;
  endtask

  // Memory responder: the bench is the system memory
  always @(negedge clock) begin
    if (reset) begin
      mem_ready = 1'b0;
      tbmem = img;
    end else if (!mem_req) begin
      mem_ready = 1'b0;
    end else begin
      case (ready_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ($urandom_range(0, 2) != 0);
        2:       mem_ready = 1'b0;
        default: mem_ready = !mem_we;
      endcase
      if (mem_ready) begin
        if (mem_we) tbmem[mem_addr[11:2]] = mem_wdata;
        else        mem_rdata = tbmem[mem_addr[11:2]];
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted request
  always @(negedge clock) begin : monitor
    txn_t t;
    #1;
    if (reset) begin
      cyc = 0;
      last_fetch = 0;
      ret_cnt = 0;
      ret_cycs.delete();
    end else begin
      cyc++;
      if (retire) begin
        ret_cnt++;
        ret_cycs.push_back(cyc);
      end
      if (mon_en && mem_req && mem_ready) begin
        if (expq.size() == 0) begin
          if (!allow_extra) begin
            checks++;
            errors++;
            $display("FAIL extra_req actual addr=%h we=%0d expected no request", mem_addr, mem_we);
          end
        end else begin
          t = expq.pop_front();
          check("req_we", {31'h0, mem_we}, {31'h0, t.we});
          check("req_addr", {16'h0, mem_addr}, t.addr & AMASK);
          if (t.we) check("req_wdata", mem_wdata, t.wdata);
          if (t.fetch && gap_chk && t.gap > 0) check("fetch_gap", cyc - last_fetch, t.gap);
          if (t.fetch) last_fetch = cyc;
        end
      end
    end
  end

  // Instruction-level reference model: architectural effects plus bus traffic
  task automatic run_model(input int max_steps);
    logic [31:0] pc, ins, rsv, rtv, sx, ea, res;
    logic [4:0]  dst;
    int          prev;
    bit          wr, done;
    pc = RST_PC;
    prev = 0;
    exp_halt = 0;
    exp_trap = 0;
    exp_ret = 0;
    for (int r = 0; r < 32; r++) mreg[r] = 32'h0;
    for (int s = 0; s < max_steps; s++) begin
      expq.push_back('{we: 1'b0, fetch: 1'b1, addr: pc, wdata: 32'h0, gap: prev});
      ins = mmem[pc[11:2]];
      pc = pc + 32'd4;
      rsv = mreg[ins[25:21]];
      rtv = mreg[ins[20:16]];
      sx = {{16{ins[15]}}, ins[15:0]};
      ea = rsv + sx;
      wr = 1'b0; done = 1'b0; dst = ins[20:16]; res = 32'h0; prev = 4;
      case (ins[31:26])
        6'h00: begin
          dst = ins[15:11];
          wr = 1'b1;
          case (ins[5:0])
            6'h21: res = rsv + rtv;
            6'h23: res = rsv - rtv;
            6'h24: res = rsv & rtv;
            6'h25: res = rsv | rtv;
            6'h2A: res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
            6'h00: res = rtv << ins[10:6];
            6'h0C: begin exp_halt = 1; done = 1; end
            default: begin exp_trap = 1; done = 1; end
          endcase
        end
        6'h09: begin res = ea; wr = 1'b1; end
        6'h0D: begin res = rsv | {16'h0, ins[15:0]}; wr = 1'b1; end
        6'h23: if (ea[1:0] != 2'b00) begin exp_trap = 1; done = 1; end
               else begin
                 expq.push_back('{we: 1'b0, fetch: 1'b0, addr: ea, wdata: 32'h0, gap: 0});
                 res = mmem[ea[11:2]];
                 wr = 1'b1;
                 prev = 5;
               end
        6'h2B: if (ea[1:0] != 2'b00) begin exp_trap = 1; done = 1; end
               else begin
                 expq.push_back('{we: 1'b1, fetch: 1'b0, addr: ea, wdata: rtv, gap: 0});
                 mmem[ea[11:2]] = rtv;
               end
        6'h04: begin if (rsv == rtv) pc = pc + (sx << 2); prev = 3; end
        6'h02: begin pc = {pc[31:28], ins[25:0], 2'b00}; prev = 3; end
        default: begin exp_trap = 1; done = 1; end
      endcase
      if (done) break;
      if (wr && dst != 5'd0) mreg[dst] = res;
      exp_ret++;
    end
    exp_pc = pc;
  endtask

  task automatic begin_run(input int mode, input bit gchk, input bit aex, input int steps);
    mon_en = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    expq.delete();
    ready_mode = mode;
    gap_chk = gchk;
    allow_extra = aex;
    mmem = img;
    run_model(steps);
    mon_en = 1;
    #2 reset = 1'b0;
  endtask

  task automatic finish_run(input string nm, input int budget);
    bit ended;
    ended = 0;
    for (int i = 0; i < budget; i++) begin
      if (halted || trap || (allow_extra && expq.size() == 0)) begin
        ended = 1;
        break;
      end
      @(negedge clock);
    end
    check({nm, "_done"}, {31'h0, ended}, 32'd1);
    repeat (3) @(negedge clock);
    #2;
    check({nm, "_queue_left"}, expq.size(), 32'd0);
    check({nm, "_halted"}, {31'h0, halted}, {31'h0, exp_halt});
    check({nm, "_trap"}, {31'h0, trap}, {31'h0, exp_trap});
    if (!allow_extra) begin
      check({nm, "_pc"}, pc_out, exp_pc);
      check({nm, "_retires"}, ret_cnt, exp_ret);
      check({nm, "_req_idle"}, {31'h0, mem_req}, 32'd0);
    end
    mon_en = 0;
  endtask

  task automatic gen_random();
    logic [4:0]  rs, rt, rd;
    logic [31:0] pc;
    int          k;
    fill_random();
    pc = RST_PC;
    for (int i = 0; i < 20; i++) begin
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      k = $urandom_range(0, 10);
      case (k)
        0: put(pc, r_op(6'h21, rd, rs, rt, 5'd0));
        1: put(pc, r_op(6'h23, rd, rs, rt, 5'd0));
        2: put(pc, r_op(6'h24, rd, rs, rt, 5'd0));
        3: put(pc, r_op(6'h25, rd, rs, rt, 5'd0));
        4: put(pc, r_op(6'h2A, rd, rs, rt, 5'd0));
        5: put(pc, r_op(6'h00, rd, 5'd0, rt, 5'($urandom_range(0, 31))));
        6: put(pc, i_op(6'h09, rt, rs, 16'($urandom)));
        7: put(pc, i_op(6'h0D, rt, rs, 16'($urandom)));
        8: put(pc, i_op(6'h2B, rt, 5'd0, 16'($urandom_range(0, 15) * 4)));
        9: put(pc, i_op(6'h23, rt, 5'd0, 16'($urandom_range(0, 15) * 4)));
        default: put(pc, i_op(6'h04, rt, rs, 16'($urandom_range(1, 3))));
      endcase
      pc = pc + 32'd4;
    end
    for (int r = 1; r < 8; r++) begin
      put(pc, i_op(6'h2B, 5'(r), 5'd0, 16'(32'h80 + 4 * r)));
      pc = pc + 32'd4;
    end
    put(pc, r_op(6'h0C, 5'd0, 5'd0, 5'd0, 5'd0));
  endtask

  initial begin
    bit found;

    // Stalled fetch, pending store, and reset in the middle of it
    fill_random();
    put(32'h100, i_op(6'h09, 5'd3, 5'd0, 16'd2));
    put(32'h104, i_op(6'h2B, 5'd3, 5'd0, 16'd8));
    put(32'h108, r_op(6'h0C, 5'd0, 5'd0, 5'd0, 5'd0));
    ready_mode = 2;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #2;
      check("stall_req", {31'h0, mem_req}, 32'd1);
      check("stall_addr", {16'h0, mem_addr}, 32'h100);
      check("stall_we", {31'h0, mem_we}, 32'd0);
    end
    ready_mode = 3;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      #2;
      if (mem_req && mem_we) found = 1;
    end
    check("store_seen", {31'h0, found}, 32'd1);
    check("store_addr", {16'h0, mem_addr}, 32'h8);
    check("store_wdata", mem_wdata, 32'h2);
    repeat (2) @(negedge clock);
    #2 check("store_held", {31'h0, mem_req & mem_we}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("reset_drop_req", {31'h0, mem_req}, 32'd0);
    check("reset_pc", pc_out, RST_PC);
    check("reset_flags", {29'h0, retire, halted, trap}, 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    #2;
    check("restart_req", {31'h0, mem_req}, 32'd1);
    check("restart_addr", {16'h0, mem_addr}, RST_PC);
    check("restart_we", {31'h0, mem_we}, 32'd0);

    // Arithmetic, store/load round trip, $0 behaviour, retire timing
    fill_random();
    put(32'h100, i_op(6'h09, 5'd1, 5'd0, 16'd5));
    put(32'h104, i_op(6'h09, 5'd2, 5'd0, 16'hFFFD));
    put(32'h108, r_op(6'h21, 5'd3, 5'd1, 5'd2, 5'd0));
    put(32'h10C, r_op(6'h2A, 5'd4, 5'd2, 5'd1, 5'd0));
    put(32'h110, i_op(6'h2B, 5'd3, 5'd0, 16'h8));
    put(32'h114, i_op(6'h23, 5'd5, 5'd0, 16'h8));
    put(32'h118, i_op(6'h2B, 5'd5, 5'd0, 16'hC));
    put(32'h11C, i_op(6'h09, 5'd0, 5'd0, 16'd7));
    put(32'h120, r_op(6'h21, 5'd6, 5'd0, 5'd0, 5'd0));
    put(32'h124, i_op(6'h2B, 5'd6, 5'd0, 16'h10));
    put(32'h128, i_op(6'h2B, 5'd4, 5'd0, 16'h14));
    put(32'h12C, r_op(6'h0C, 5'd0, 5'd0, 5'd0, 5'd0));
    put(32'h010, 32'hDEAD_BEEF);
    begin_run(0, 1, 0, 100);
    finish_run("arith", 300);
    for (int i = 0; i < 4; i++)
      check($sformatf("retire_cycle%0d", i), (i < ret_cycs.size()) ? ret_cycs[i] : 0, 4 * (i + 1));
    check("arith_pc_const", pc_out, 32'h130);
    check("mem_sw3", tbmem[2], 32'd2);
    check("mem_lw5", tbmem[3], 32'd2);
    check("mem_r0_sum", tbmem[4], 32'd0);
    check("mem_slt", tbmem[5], 32'd1);

    // Branch-to-self loop
    fill_random();
    put(32'h100, i_op(6'h09, 5'd1, 5'd0, 16'd1));
    put(32'h104, i_op(6'h04, 5'd1, 5'd1, 16'hFFFF));
    begin_run(0, 1, 1, 8);
    finish_run("beq_loop", 200);

    // Not-taken beq, jump back, taken beq on second pass
    fill_random();
    put(32'h100, i_op(6'h09, 5'd7, 5'd7, 16'd1));
    put(32'h104, i_op(6'h09, 5'd2, 5'd0, 16'd2));
    put(32'h108, i_op(6'h04, 5'd2, 5'd7, 16'd3));
    put(32'h10C, {6'h02, 26'h40});
    put(32'h110, ILLEGAL);
    put(32'h114, ILLEGAL);
    put(32'h118, i_op(6'h2B, 5'd7, 5'd0, 16'h18));
    put(32'h11C, r_op(6'h0C, 5'd0, 5'd0, 5'd0, 5'd0));
    begin_run(0, 1, 0, 100);
    finish_run("branch_jump", 300);
    check("bj_halted", {31'h0, halted}, 32'd1);
    check("bj_pc_const", pc_out, 32'h120);
    check("bj_mem", tbmem[6], 32'd2);

    // Misaligned load, bad opcode, bad funct
    fill_random();
    put(32'h100, i_op(6'h23, 5'd1, 5'd0, 16'h2));
    begin_run(1, 0, 0, 10);
    finish_run("misaligned", 100);
    check("mis_trap_const", {30'h0, halted, trap}, 32'd1);
    check("mis_pc_const", pc_out, 32'h104);

    fill_random();
    put(32'h100, ILLEGAL);
    begin_run(0, 0, 0, 10);
    finish_run("bad_op", 100);
    check("badop_trap_const", {30'h0, halted, trap}, 32'd1);

    fill_random();
    put(32'h100, i_op(6'h0D, 5'd1, 5'd0, 16'h1234));
    put(32'h104, r_op(6'h20, 5'd2, 5'd1, 5'd1, 5'd0));
    begin_run(0, 0, 0, 10);
    finish_run("bad_funct", 100);
    check("badfn_pc_const", pc_out, 32'h108);

    // Randomised programs
    for (int r = 0; r < 8; r++) begin
      gen_random();
      begin_run((r < 2) ? 0 : 1, r < 2, 0, 200);
      finish_run($sformatf("rand%0d", r), 2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
